// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart transmitter among N requesters.
// Define UART_TX_SCHED_TIMEOUT_EN to add busy-handshake timeouts and the sticky err flag.
module uart_tx_sched #(
    parameter int N           = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [8*N-1:0]       req_data,
    input  logic [N-1:0]         req_par_en,
    input  logic [N-1:0]         req_par_typ,
    output logic [N-1:0]         ack,
    output logic [N-1:0]         done,
    output logic [7:0]           P_DATA,
    output logic                 DATA_valid,
    output logic                 PAR_EN,
    output logic                 PAR_TYP,
    input  logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 sched_busy,
    output logic                 err
);

    localparam int W = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   rr_q, rr_d;
    logic [W-1:0]   owner_q, owner_d;
    logic [7:0]     p_data_q, p_data_d;
    logic           par_en_q, par_en_d;
    logic           par_typ_q, par_typ_d;
    logic           dv_q, dv_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [N-1:0]   done_q, done_d;

    logic [W-1:0]   win;
    logic           found;
    int             idx;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 3) ? $clog2(TIMEOUT_CYC + 1) : 3;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
`endif

    // First pending requester at or after rr, wrapping modulo N.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_q) + k) % N;
            if (!found && req[W'(idx)]) begin
                found = 1'b1;
                win   = W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        p_data_d  = p_data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        dv_d      = 1'b0;
        ack_d     = '0;
        done_d    = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!busy && found) begin
                    owner_d    = win;
                    p_data_d   = req_data[{win, 3'b000} +: 8];
                    par_en_d   = req_par_en[win];
                    par_typ_d  = req_par_typ[win];
                    dv_d       = 1'b1;
                    ack_d[win] = 1'b1;
                    rr_d       = (win == W'(N - 1)) ? '0 : win + 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_HI;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT_HI: begin
                if (busy) begin
                    state_d = S_WAIT_LO;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (cnt_q == CW'(3)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = S_IDLE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            p_data_q  <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            dv_q      <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            p_data_q  <= p_data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            dv_q      <= dv_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ack        = ack_q;
    assign done       = done_q;
    assign P_DATA     = p_data_q;
    assign DATA_valid = dv_q;
    assign PAR_EN     = par_en_q;
    assign PAR_TYP    = par_typ_q;
    assign owner      = owner_q;
    assign sched_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small behavioural uart transmitter model.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_par_en = '0;
    logic [3:0]  req_par_typ = '0;
    logic [3:0]  ack, done;
    logic [7:0]  P_DATA;
    logic        DATA_valid, PAR_EN, PAR_TYP, busy;
    logic [1:0]  owner;
    logic        sched_busy, err;

    uart_tx_sched #(.N(4), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .req_par_en(req_par_en), .req_par_typ(req_par_typ),
        .ack(ack), .done(done), .P_DATA(P_DATA), .DATA_valid(DATA_valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .busy(busy), .owner(owner),
        .sched_busy(sched_busy), .err(err)
    );

    always #5 clk = ~clk;

    // uart model: captures on DATA_valid, busy for 10 or 11 cycles
    logic        bm, force_busy = 1'b0;
    logic [3:0]  bidx, blen;
    logic [10:0] frame;
    logic        par_bit, tx_out;
    assign par_bit = PAR_TYP ? ^P_DATA : ~^P_DATA;
    assign tx_out  = bm ? frame[bidx] : 1'b1;
    assign busy    = bm | force_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bm <= 1'b0; bidx <= '0; blen <= '0; frame <= '0;
        end else if (!bm && DATA_valid) begin
            bm    <= 1'b1;
            bidx  <= '0;
            blen  <= PAR_EN ? 4'd11 : 4'd10;
            frame <= PAR_EN ? {1'b1, par_bit, P_DATA, 1'b0} : {2'b11, P_DATA, 1'b0};
        end else if (bm) begin
            if (bidx == blen - 4'd1) bm <= 1'b0;
            else bidx <= bidx + 4'd1;
        end
    end

    int n_tests = 0, n_fail = 0;
    int cyc = 0, dv_tot = 0, done_tot = 0, ovl = 0, ackdv_bad = 0;
    int span_cnt = 0, last_span = 0, fall_cyc = 0, done_cyc = 0;
    int ack_tot[4] = '{0, 0, 0, 0};
    logic [3:0] last_done = '0;
    logic [1:0] grants[$];
    logic       tx_log[$];
    logic       open_f = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            open_f = 1'b0; busy_prev = 1'b0; span_cnt = 0;
        end else begin
            if (DATA_valid) begin
                dv_tot++;
                if (open_f) ovl++;
                open_f = 1'b1;
            end
            if ((ack != 4'b0) != DATA_valid) ackdv_bad++;
            for (int i = 0; i < 4; i++)
                if (ack[i]) begin
                    ack_tot[i]++;
                    grants.push_back(2'(i));
                end
            if (done != 4'b0) begin
                done_tot++; done_cyc = cyc; last_done = done; open_f = 1'b0;
            end
            if (busy) begin
                span_cnt++;
                tx_log.push_back(tx_out);
            end else if (busy_prev) begin
                last_span = span_cnt; span_cnt = 0; fall_cyc = cyc;
            end
            busy_prev = busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (ack != 4'b0) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int prev);
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (done_tot > prev) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    int d0, t0, a1, ovl0, g0;
    logic [9:0] txv, gv;

    initial begin
        repeat (3) @(posedge clk); #1;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dv", 32'(DATA_valid), 0);
        chk("rst_pdata", 32'(P_DATA), 0);
        chk("rst_par", 32'({PAR_EN, PAR_TYP}), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_sbusy", 32'(sched_busy), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single request, A5 without parity
        t0 = tx_log.size(); d0 = done_tot;
        req_data[7:0] = 8'hA5; req = 4'b0001;
        wait_ack("s_wait_ack");
        chk("s_ack", 32'(ack), 32'h1);
        chk("s_dv", 32'(DATA_valid), 1);
        chk("s_pdata", 32'(P_DATA), 32'hA5);
        chk("s_paren", 32'(PAR_EN), 0);
        req = 4'b0; req_data = 32'hFFFF_FFFF;
        wait_done("s_wait_done", d0);
        chk("s_done", 32'(last_done), 32'h1);
        chk("s_done_gap", 32'(done_cyc - fall_cyc), 1);
        chk("s_span", 32'(last_span), 10);
        for (int k = 0; k < 10; k++) txv[k] = tx_log[t0 + k];
        chk("s_tx", 32'(txv), 32'h34A);
        chk("s_hold", 32'(P_DATA), 32'hA5);
        chk("s_acks", 32'(ack_tot[0]), 1);
        chk("s_dvs", 32'(dv_tot), 1);

        // req[1] dropped before arbitration, req[3] stays
        @(negedge clk);
        a1 = ack_tot[1]; d0 = done_tot;
        force_busy = 1'b1; req_data = 32'h4400_2200; req = 4'b1010;
        repeat (3) @(negedge clk);
        chk("dr_hold", 32'(sched_busy), 0);
        req = 4'b1000;
        @(negedge clk) force_busy = 1'b0;
        wait_ack("dr_wait_ack");
        chk("dr_ack", 32'(ack), 32'h8);
        chk("dr_owner", 32'(owner), 3);
        chk("dr_pdata", 32'(P_DATA), 32'h44);
        req = 4'b0;
        wait_done("dr_wait_done", d0);
        chk("dr_no_ack1", 32'(ack_tot[1] - a1), 0);

        // all four continuously requesting
        @(negedge clk);
        g0 = grants.size(); d0 = done_tot; ovl0 = ovl;
        req_data = 32'h3322_1100; req = 4'b1111;
        for (int n = 0; n < 5; n++) wait_ack("a4_wait_ack");
        req = 4'b0;
        wait_done("a4_wait_done", d0 + 4);
        for (int k = 0; k < 5; k++) gv[2*k +: 2] = grants[g0 + k];
        chk("a4_order", 32'(gv), 32'h0E4);
        chk("a4_overlap", 32'(ovl - ovl0), 0);
        chk("a4_dones", 32'(done_tot - d0), 5);

        // requester 2 with even parity, data 07
        @(negedge clk);
        t0 = tx_log.size(); d0 = done_tot;
        req_par_en = 4'b0100; req_par_typ = 4'b0100;
        req_data[23:16] = 8'h07; req = 4'b0100;
        wait_ack("p_wait_ack");
        chk("p_owner", 32'(owner), 2);
        chk("p_par", 32'({PAR_EN, PAR_TYP}), 32'h3);
        req = 4'b0;
        wait_done("p_wait_done", d0);
        chk("p_done", 32'(last_done), 32'h4);
        chk("p_span", 32'(last_span), 11);
        chk("p_parbit", 32'(tx_log[t0 + 9]), 1);
        chk("p_stop", 32'(tx_log[t0 + 10]), 1);
        req_par_en = 4'b0; req_par_typ = 4'b0;

        // reset during DATA bits
        @(negedge clk);
        d0 = done_tot;
        req_data[7:0] = 8'h5A; req = 4'b0001;
        wait_ack("mr_wait_ack");
        req = 4'b0;
        repeat (5) @(posedge clk); #1;
        chk("mr_busy", 32'(busy), 1);
        rst_n = 1'b0; #1;
        chk("mr_sbusy", 32'(sched_busy), 0);
        chk("mr_pdata", 32'(P_DATA), 0);
        chk("mr_outs", 32'({DATA_valid, PAR_EN, PAR_TYP, owner, ack, done}), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mr_no_done", 32'(done_tot - d0), 0);
        req = 4'b1001;
        wait_ack("mr_wait_ack2");
        chk("mr_fresh", 32'(ack), 32'h1);
        req = 4'b0;
        wait_done("mr_wait_done", d0);

        // busy stuck high after a grant
        @(negedge clk);
        d0 = done_tot;
        req = 4'b0010;
        wait_ack("sb_wait_ack");
        req = 4'b0;
        @(negedge clk) force_busy = 1'b1;
        repeat (100) @(negedge clk);
`ifdef UART_TX_SCHED_TIMEOUT_EN
        chk("sb_err", 32'(err), 1);
        chk("sb_idle", 32'(sched_busy), 0);
        force_busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_no_done", 32'(done_tot - d0), 0);
        chk("sb_err_sticky", 32'(err), 1);
`else
        chk("sb_err", 32'(err), 0);
        chk("sb_waiting", 32'(sched_busy), 1);
        force_busy = 1'b0;
        wait_done("sb_wait_done", d0);
        chk("sb_done", 32'(last_done), 32'h2);
`endif
        chk("ack_dv_align", 32'(ackdv_bad), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `uart` transmitter between `N` byte requesters. It arbitrates pending requests and drives the UART's `P_DATA`, `DATA_valid`, `PAR_EN` and `PAR_TYP` inputs. It tracks the UART's `busy` output to sequence exactly one frame at a time, and returns a per-requester accept (`ack`) and completion (`done`) pulse. It sits between the system's byte producers and the `uart` instance, and shares that instance's `clk` and `rst_n`.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `TIMEOUT_CYC`, 64: maximum cycles in WAIT_LO before abort (only with the timeout macro).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester level request; must be held with its data until `ack`.
- `req_data`  in  8N  byte for requester i at `[8i+7:8i]`.
- `req_par_en`  in  N  parity enable for requester i's frame.
- `req_par_typ`  in  N  parity type for requester i (0 = odd/XNOR, 1 = even/XOR, matching `uart`).
- `ack`  out  N  one-cycle pulse: byte accepted.
- `done`  out  N  one-cycle pulse: frame fully shifted out.
- `P_DATA`  out  8  to `uart`.
- `DATA_valid`  out  1  to `uart`; one-cycle pulse per frame.
- `PAR_EN`  out  1  to `uart`; held for the whole frame.
- `PAR_TYP`  out  1  to `uart`; held for the whole frame.
- `busy`  in  1  from `uart`.
- `owner`  out  $clog2(N)  index of the current or last granted requester.
- `sched_busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky timeout flag.

## Operation
- States:
  - IDLE: if `busy`=0 and `req`≠0, select the winner, register `P_DATA`/`PAR_EN`/`PAR_TYP`/`owner`, assert `DATA_valid` and `ack[winner]`, then go to ISSUE.
  - ISSUE: deassert `DATA_valid`, then go to WAIT_HI.
  - WAIT_HI: on `busy`=1, go to WAIT_LO.
  - WAIT_LO: on `busy`=0, pulse `done[owner]`, then go to IDLE.
- Arbitration: round-robin. The pointer `rr` resets to 0. Search order is `rr`, `rr+1`, …, mod N. After a grant to i, `rr` becomes (i+1) mod N.
- Only `req` bits high at the arbitration edge compete. A requester that drops `req` early is skipped, with no `ack`.
- `ack` and `DATA_valid` are high in the same cycle. Requesters may change `req_data` after `ack`.
- `P_DATA`, `PAR_EN` and `PAR_TYP` hold their values from grant until the next grant.
- Reset values:
  - `ack`=0, `done`=0, `DATA_valid`=0, `P_DATA`=0, `PAR_EN`=0, `PAR_TYP`=0, `owner`=0, `sched_busy`=0, `err`=0.
  - state=IDLE, `rr`=0.
- Reset mid-frame: all state is cleared immediately, with no `done`. The `uart` is reset by the same `rst_n`.

## Timing
- `req[i]` rising before edge E (scheduler IDLE, `busy`=0): `DATA_valid` and `ack[i]` are high for the cycle after E. The `uart` captures the byte at E+1, and `busy` is high after E+1.
- `busy` stays high through START, 8 DATA, optional PARITY and STOP.
- `uart` busy-high span: 10 cycles without parity, 11 with parity.
- `done[i]` pulses the cycle after the scheduler samples `busy`=0.
- Back-to-back operation: the next `DATA_valid` comes no earlier than the cycle after `done`. There is no overlap between frames.
- If `busy`=1 in IDLE (external use of the uart), no grant is made until it clears.

## Configuration
- `UART_TX_SCHED_TIMEOUT_EN` defined:
  - WAIT_HI aborts if `busy` is not seen high within 4 cycles.
  - WAIT_LO aborts after `TIMEOUT_CYC` cycles.
  - An abort sets `err`=1 (sticky until reset) and returns to IDLE without `done`. `rr` still advances.
- Not defined: the scheduler waits indefinitely, and `err` is tied to 0.

## Test plan
- Single request, N=4: `req`=0001, `req_data[7:0]`=8'hA5, parity off. Expect:
  - one `ack[0]` and one `DATA_valid` with `P_DATA`=A5;
  - TX_OUT = 0,1,0,1,0,0,1,0,1,1;
  - `done[0]` the cycle after `busy` falls.
- All four requesting continuously: grants are 0,1,2,3,0. Each `ack` is followed by that requester's `done` before the next `DATA_valid`.
- Requester 2 with `req_par_en`=1, `req_par_typ`=1, data 8'h07: the parity bit on TX_OUT is 1, and the `busy` span is 11 cycles.
- `req[1]` dropped one cycle before the arbitration edge while `req[3]` is high: `ack[3]` only; `rr` becomes 0.
- `rst_n` pulsed low during DATA of a frame: all outputs return to reset values at once, and no `done` is pulsed. After release, a fresh `req[0]` is granted first.
- Macro defined, `busy` forced high for 100 cycles after a grant (`TIMEOUT_CYC`=64): `err`=1 after 64 WAIT_LO cycles, the scheduler returns to IDLE, and no `done` is pulsed.
